encrypt_v2: RTL and testbench



---
 rtl/encrypt_v2_pkg.sv | 25 ++
 rtl/encrypt_v2_present_round.sv | 37 +++
 rtl/encrypt_v2.sv | 74 +++++++
 tb/tb_encrypt_v2.sv | 108 ++++++++++
 4 files changed

// File: rtl/encrypt_v2_pkg.sv
// Shared constants, S-box table and FSM state type for the iterative PRESENT-80 engine.
package encrypt_v2_pkg;

    localparam int unsigned N_K    = 80;
    localparam int unsigned N_B    = 64;
    localparam int unsigned ROUNDS = 31;

    localparam logic [4:0] LAST_ROUND = 5'(ROUNDS);

    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        return SBOX[x];
    endfunction

endpackage

// File: rtl/encrypt_v2_present_round.sv
// One combinational PRESENT round: add round key, S-box layer, pLayer, and key schedule step.
module encrypt_v2_present_round
    import encrypt_v2_pkg::*;
(
    input  logic [N_B-1:0] state_i,
    input  logic [N_K-1:0] key_i,
    input  logic [4:0]     round_i,
    output logic [N_B-1:0] state_o,
    output logic [N_K-1:0] key_o
);

    logic [N_B-1:0] mixed;
    logic [N_B-1:0] subst;
    logic [N_K-1:0] rotated;

    always_comb begin
        mixed = state_i ^ key_i[N_K-1:N_K-N_B];
        subst = '0;
        for (int unsigned i = 0; i < N_B / 4; i++) begin
            subst[4*i +: 4] = sbox4(mixed[4*i +: 4]);
        end
        // pLayer: bit i lands at (16*i) mod 63; the top bit is a fixed point
        state_o = '0;
        for (int unsigned i = 0; i < N_B - 1; i++) begin
            state_o[(16 * i) % (N_B - 1)] = subst[i];
        end
        state_o[N_B-1] = subst[N_B-1];
    end

    always_comb begin
        rotated        = {key_i[18:0], key_i[N_K-1:19]};
        key_o          = rotated;
        key_o[79:76]   = sbox4(rotated[79:76]);
        key_o[19:15]   = rotated[19:15] ^ round_i;
    end

endmodule

// File: rtl/encrypt_v2.sv
// Iterative PRESENT-80 encryptor, one round per clock, behind a 4-phase req/ack handshake.
module encrypt_v2
    import encrypt_v2_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req,
    input  logic [N_K-1:0] k,
    input  logic [N_B-1:0] m,
    output logic           ack,
    output logic [N_B-1:0] c
);

    state_e         fsm_q;
    logic [N_B-1:0] state_q, state_d;
    logic [N_K-1:0] key_q, key_d;
    logic [4:0]     round_q;
    logic [N_B-1:0] c_q;
    logic           ack_q;

    encrypt_v2_present_round u_round (
        .state_i (state_q),
        .key_i   (key_q),
        .round_i (round_q),
        .state_o (state_d),
        .key_o   (key_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
            c_q     <= '0;
            ack_q   <= 1'b0;
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (req) begin
                        state_q <= m;
                        key_q   <= k;
                        round_q <= 5'd1;
                        fsm_q   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_q <= state_d;
                    key_q   <= key_d;
                    if (round_q == LAST_ROUND) begin
                        fsm_q <= ST_DONE;
                    end else begin
                        round_q <= round_q + 5'd1;
                    end
                end
                ST_DONE: begin
                    // First DONE edge whitens with K32; afterwards wait for the host to drop req
                    if (!ack_q) begin
                        c_q   <= state_q ^ key_q[N_K-1:N_K-N_B];
                        ack_q <= 1'b1;
                    end else if (!req) begin
                        ack_q <= 1'b0;
                        fsm_q <= ST_IDLE;
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

    assign ack = ack_q;
    assign c   = c_q;

endmodule

// File: tb/tb_encrypt_v2.sv
// Directed-vector bench for encrypt_v2 using published PRESENT-80 test vectors.
module tb_encrypt_v2;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [79:0] k;
    logic [63:0] m;
    logic        ack;
    logic [63:0] c;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    encrypt_v2 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .k     (k),
        .m     (m),
        .ack   (ack),
        .c     (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_vec(input string tag, input logic [79:0] key, input logic [63:0] pt,
                           input logic [63:0] exp, input int unsigned hold);
        int unsigned n;
        logic        got;
        @(negedge clk);
        k   = key;
        m   = pt;
        req = 1'b1;
        @(posedge clk);
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            got = ack;
        end
        check({tag, " latency"}, 64'(n), 64'd32);
        check({tag, " c"}, c, exp);
        for (int unsigned i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, " hold ack"}, 64'(ack), 64'd1);
            check({tag, " hold c"}, c, exp);
        end
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " ack fall"}, 64'(ack), 64'd0);
        check({tag, " c kept"}, c, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 1'b0;
        k     = '0;
        m     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset ack", 64'(ack), 64'd0);
        check("reset c", c, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec("k0_m0", 80'h0, 64'h0, 64'h5579c1387b228445, 0);
        run_vec("k1_m0", {80{1'b1}}, 64'h0, 64'he72c46c0f5945049, 0);
        run_vec("k0_m1", 80'h0, {64{1'b1}}, 64'ha112ffc72f68417b, 0);
        run_vec("k1_m1", {80{1'b1}}, {64{1'b1}}, 64'h3333dcd3213210d2, 0);

        // Abort an encryption partway through RUN
        @(negedge clk);
        k   = {80{1'b1}};
        m   = 64'h0123456789abcdef;
        req = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun reset ack", 64'(ack), 64'd0);
        check("midrun reset c", c, 64'd0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        run_vec("after_reset", 80'h0, 64'h0, 64'h5579c1387b228445, 0);
        run_vec("hold", {80{1'b1}}, 64'h0, 64'he72c46c0f5945049, 10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
